// File: rtl/rob_pkg.sv
// Shared widths, exception codes and entry types for the reorder buffer.
package rob_pkg;

    localparam int unsigned ROB_DEPTH_DEFAULT = 16;
    localparam int unsigned REG_ADDR_W        = 5;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned PC_W              = 32;
    localparam int unsigned EXC_TYPE_W        = 4;

    typedef logic [EXC_TYPE_W-1:0] exc_type_t;

    localparam exc_type_t EXC_TYPE_NULL = 4'h0;
    localparam exc_type_t EXC_TYPE_IF   = 4'h1;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  reg_write_en;
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     data;
        exc_type_t             exc_type;
        logic                  is_delayslot;
        logic [PC_W-1:0]       pc;
    } rob_entry_t;

    // Reduced entry view consumed by the commit selector.
    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  reg_write_en;
        logic [REG_ADDR_W-1:0] reg_addr;
        exc_type_t             exc_type;
        logic [1:0]            pc_lo;
    } rob_view_t;

    function automatic logic exc_or_misaligned(exc_type_t t, logic [1:0] pc_lo);
        return (t != EXC_TYPE_NULL) || (pc_lo != 2'b00);
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Combinational commit-slot enables, head exception detect and same-cycle WAW masking.
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 2
) (
    input  logic                    flush_i,
    input  rob_view_t               slot_i [COMMIT_WIDTH],
    output logic [COMMIT_WIDTH-1:0] commit_en_c,
    output logic [COMMIT_WIDTH-1:0] commit_we_c,
    output logic                    exc_valid_c,
    output exc_type_t               exc_type_c
);

    logic [COMMIT_WIDTH-1:0] we_raw;

    always_comb begin
        commit_en_c = '0;
        commit_we_c = '0;
        we_raw      = '0;
        exc_type_c  = EXC_TYPE_NULL;

        exc_valid_c = slot_i[0].valid && slot_i[0].done &&
                      exc_or_misaligned(slot_i[0].exc_type, slot_i[0].pc_lo);
        if (exc_valid_c) begin
            exc_type_c = (slot_i[0].pc_lo != 2'b00) ? EXC_TYPE_IF : slot_i[0].exc_type;
        end

        commit_en_c[0] = slot_i[0].valid && slot_i[0].done && !exc_valid_c && !flush_i;
        // Younger slots retire only behind a committing elder and never carry an exception.
        for (int i = 1; i < COMMIT_WIDTH; i++) begin
            commit_en_c[i] = commit_en_c[i-1] && slot_i[i].valid && slot_i[i].done &&
                             !exc_or_misaligned(slot_i[i].exc_type, slot_i[i].pc_lo);
        end

        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            we_raw[i] = commit_en_c[i] && slot_i[i].reg_write_en;
        end
        commit_we_c = we_raw;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
                if (we_raw[i] && we_raw[j] && (slot_i[i].reg_addr == slot_i[j].reg_addr)) begin
                    commit_we_c[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rob_queue.sv
// Circular reorder buffer: in-order allocate, out-of-order write-back, in-order commit.
// Define ROB_BYPASS_EN to add operand lookup/forwarding ports for the II stage.
module rob_queue
    import rob_pkg::*;
#(
    parameter  int unsigned DEPTH        = ROB_DEPTH_DEFAULT,
    parameter  int unsigned CDB_NUM      = 2,
    parameter  int unsigned COMMIT_WIDTH = 2,
    localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic                               disp_reg_write_en,
    input  logic [REG_ADDR_W-1:0]              disp_reg_addr,
    input  logic [EXC_TYPE_W-1:0]              disp_exc_type,
    input  logic                               disp_is_delayslot,
    input  logic [PC_W-1:0]                    disp_pc,
    output logic [ADDR_W-1:0]                  disp_id,
    input  logic [CDB_NUM-1:0]                 wb_valid,
    input  logic [CDB_NUM*ADDR_W-1:0]          wb_id,
    input  logic [CDB_NUM*DATA_W-1:0]          wb_data,
    input  logic [CDB_NUM*EXC_TYPE_W-1:0]      wb_exc_type,
`ifdef ROB_BYPASS_EN
    input  logic [2*ADDR_W-1:0]                rd_id,
    output logic [1:0]                         rd_ready,
    output logic [2*DATA_W-1:0]                rd_data,
`endif
    output logic [COMMIT_WIDTH-1:0]            commit_en,
    output logic [COMMIT_WIDTH-1:0]            commit_reg_write_en,
    output logic [COMMIT_WIDTH*REG_ADDR_W-1:0] commit_reg_addr,
    output logic [COMMIT_WIDTH*DATA_W-1:0]     commit_reg_data,
    output logic [COMMIT_WIDTH*ADDR_W-1:0]     commit_id,
    output logic                               exc_valid,
    output logic [EXC_TYPE_W-1:0]              exc_type,
    output logic                               exc_is_delayslot,
    output logic [PC_W-1:0]                    exc_pc,
    output logic [ADDR_W:0]                    count,
    output logic                               empty
);

    rob_entry_t              ent_q [DEPTH];
    rob_entry_t              ent_d [DEPTH];
    logic [ADDR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [ADDR_W:0]         count_q, count_d;
    rob_view_t               slot_view [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] cen_c, cwe_c;
    logic                    exc_valid_c;
    exc_type_t               exc_type_c;
    logic                    accept_c;
    logic [ADDR_W:0]         n_commit_c;
    logic [ADDR_W-1:0]       wb_idx;

    assign disp_ready = count_q < (ADDR_W+1)'(DEPTH);
    assign disp_id    = tail_q;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign accept_c   = disp_valid && disp_ready && !flush && !exc_valid_c;

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            slot_view[i].valid        = ent_q[head_q + ADDR_W'(i)].valid;
            slot_view[i].done         = ent_q[head_q + ADDR_W'(i)].done;
            slot_view[i].reg_write_en = ent_q[head_q + ADDR_W'(i)].reg_write_en;
            slot_view[i].reg_addr     = ent_q[head_q + ADDR_W'(i)].reg_addr;
            slot_view[i].exc_type     = ent_q[head_q + ADDR_W'(i)].exc_type;
            slot_view[i].pc_lo        = ent_q[head_q + ADDR_W'(i)].pc[1:0];
        end
    end

    rob_commit_select #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_commit_select (
        .flush_i     (flush),
        .slot_i      (slot_view),
        .commit_en_c (cen_c),
        .commit_we_c (cwe_c),
        .exc_valid_c (exc_valid_c),
        .exc_type_c  (exc_type_c)
    );

    // Commit and exception outputs are zero unless the slot is actually retiring/excepting.
    always_comb begin
        commit_en           = cen_c;
        commit_reg_write_en = cwe_c;
        commit_reg_addr     = '0;
        commit_reg_data     = '0;
        commit_id           = '0;
        n_commit_c          = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (cen_c[i]) begin
                commit_reg_addr[i*REG_ADDR_W +: REG_ADDR_W] = ent_q[head_q + ADDR_W'(i)].reg_addr;
                commit_reg_data[i*DATA_W +: DATA_W]         = ent_q[head_q + ADDR_W'(i)].data;
                commit_id[i*ADDR_W +: ADDR_W]               = head_q + ADDR_W'(i);
                n_commit_c                                  = n_commit_c + (ADDR_W+1)'(1);
            end
        end
        exc_valid        = exc_valid_c;
        exc_type         = exc_type_c;
        exc_is_delayslot = exc_valid_c && ent_q[head_q].is_delayslot;
        exc_pc           = exc_valid_c ? ent_q[head_q].pc : '0;
    end

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wb_idx  = '0;
        if (flush || exc_valid_c) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].done  = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (cen_c[i]) begin
                    ent_d[head_q + ADDR_W'(i)].valid = 1'b0;
                    ent_d[head_q + ADDR_W'(i)].done  = 1'b0;
                end
            end
            // Ascending scan: an entry claimed by a lower channel is done in ent_d and blocks the rest.
            for (int k = 0; k < CDB_NUM; k++) begin
                wb_idx = wb_id[k*ADDR_W +: ADDR_W];
                if (wb_valid[k] && ent_q[wb_idx].valid && !ent_q[wb_idx].done && !ent_d[wb_idx].done) begin
                    ent_d[wb_idx].done = 1'b1;
                    ent_d[wb_idx].data = wb_data[k*DATA_W +: DATA_W];
                    if (wb_exc_type[k*EXC_TYPE_W +: EXC_TYPE_W] != EXC_TYPE_NULL) begin
                        ent_d[wb_idx].exc_type = wb_exc_type[k*EXC_TYPE_W +: EXC_TYPE_W];
                    end
                end
            end
            if (accept_c) begin
                ent_d[tail_q].valid        = 1'b1;
                ent_d[tail_q].done         = (disp_exc_type != EXC_TYPE_NULL);
                ent_d[tail_q].reg_write_en = disp_reg_write_en;
                ent_d[tail_q].reg_addr     = disp_reg_addr;
                ent_d[tail_q].data         = '0;
                ent_d[tail_q].exc_type     = disp_exc_type;
                ent_d[tail_q].is_delayslot = disp_is_delayslot;
                ent_d[tail_q].pc           = disp_pc;
                tail_d                     = tail_q + ADDR_W'(1);
            end
            head_d  = head_q + ADDR_W'(n_commit_c);
            count_d = count_q + (ADDR_W+1)'(accept_c) - n_commit_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef ROB_BYPASS_EN
    // Operand lookup: stored result if done, else a same-cycle write-back hit (lowest channel wins).
    always_comb begin
        rd_ready = '0;
        rd_data  = '0;
        for (int r = 0; r < 2; r++) begin
            if (ent_q[rd_id[r*ADDR_W +: ADDR_W]].valid && ent_q[rd_id[r*ADDR_W +: ADDR_W]].done) begin
                rd_ready[r]                = 1'b1;
                rd_data[r*DATA_W +: DATA_W] = ent_q[rd_id[r*ADDR_W +: ADDR_W]].data;
            end else if (ent_q[rd_id[r*ADDR_W +: ADDR_W]].valid) begin
                for (int k = int'(CDB_NUM) - 1; k >= 0; k--) begin
                    if (wb_valid[k] && (wb_id[k*ADDR_W +: ADDR_W] == rd_id[r*ADDR_W +: ADDR_W])) begin
                        rd_ready[r]                = 1'b1;
                        rd_data[r*DATA_W +: DATA_W] = wb_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: doc/rob_queue.md
Name: rob_queue

Overview:
- Parametrised circular reorder buffer: DEPTH entries, CDB_NUM completion write-back channels, COMMIT_WIDTH in-order commit slots.
- Allocates one entry per dispatch and returns its ref id to the regfile rename table and the II stage.
- Collects results and exceptions from the functional units.
- Retires done entries in order to the regfile and reports the oldest exception to the pipeline controller.

Parameters:
- DEPTH, 16, number of entries; power of two, >=4
- CDB_NUM, 2, number of write-back channels
- COMMIT_WIDTH, 2, commit slots per cycle; legal values 1 or 2
- ADDR_W, $clog2(DEPTH), ref id width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  pipeline-controller flush; clears all entries
- disp_valid  in  1  ID stage offers an instruction
- disp_ready  out  1  entry available (count < DEPTH)
- disp_reg_write_en  in  1  instruction writes a GPR
- disp_reg_addr  in  `REG_ADDR_BUS`  destination GPR
- disp_exc_type  in  `EXC_TYPE_BUS`  exception detected before issue
- disp_is_delayslot  in  1  delay-slot flag
- disp_pc  in  `ADDR_BUS`  instruction PC
- disp_id  out  ADDR_W  ref id allocated (equals tail)
- wb_valid  in  CDB_NUM  per-channel result valid
- wb_id  in  CDB_NUM*ADDR_W  per-channel target ref id
- wb_data  in  CDB_NUM*32  per-channel result
- wb_exc_type  in  CDB_NUM*`EXC_TYPE_BUS`  per-channel exception
- commit_en  out  COMMIT_WIDTH  slot retires this cycle
- commit_reg_write_en  out  COMMIT_WIDTH  slot writes the regfile
- commit_reg_addr  out  COMMIT_WIDTH*5  per-slot destination register
- commit_reg_data  out  COMMIT_WIDTH*32  per-slot data
- commit_id  out  COMMIT_WIDTH*ADDR_W  per-slot ref id, for rename-table release
- exc_valid  out  1  head entry raises an exception
- exc_type  out  `EXC_TYPE_BUS`  exception type
- exc_is_delayslot  out  1  delay-slot flag of the excepting entry
- exc_pc  out  `ADDR_BUS`  PC of the excepting entry
- count  out  ADDR_W+1  number of occupied entries
- empty  out  1  count == 0

Behaviour:
- Storage per entry: valid, done, reg_write_en, reg_addr, data, exc_type, is_delayslot, pc.
- Pointers and occupancy: head and tail ADDR_W bits, wrapping modulo DEPTH; count is a register.
- Reset (rst=0 at clk edge): head=tail=count=0; all valid/done=0; empty=1, disp_ready=1; all commit_* and exc_* outputs =0.
- Dispatch accept = disp_valid && disp_ready && !flush && !exc_valid.
  - On accept: entry[tail] valid=1.
  - done=1 if disp_exc_type != EXC_TYPE_NULL, else 0.
  - tail increments.
- disp_ready derives only from registered count, so a full ROB accepts nothing even when a commit occurs the same cycle.
- Write-back (channel k): if wb_valid[k] and entry[wb_id] is valid and not done, set done=1 and data=wb_data.
  - exc_type is overwritten only if wb exc != NULL.
  - Write-backs to invalid or already-done entries are ignored.
  - Two channels targeting the same id in one cycle: the lowest k wins.
  - A write-back becomes visible to commit one cycle later.
- Head exception: exc_valid=1 when head is valid && done && (exc_type != NULL || pc[1:0] != 0).
  - exc_type = EXC_TYPE_IF if pc misaligned, else the stored type.
  - exc_valid is combinational from registered state.
  - The excepting entry is not committed.
  - On the next edge the ROB self-clears exactly as for flush.
- Commit slot 0: head valid && done && !exc_valid.
- Commit slot 1 (COMMIT_WIDTH=2): slot 0 commits && head+1 valid && done && exc NULL && pc aligned. An exception in head+1 is reported only once it reaches head.
- Same-cycle write-after-write: if both slots write the same register, commit_reg_write_en[0] is masked.
- Commit outputs are combinational; head and count advance by the number of committed slots at the edge.
- Register 0 is passed through unchanged; the regfile ignores it.
- flush=1 dominates: clears valid/done, head=tail=count=0, blocks dispatch; commit_en is forced to 0 that cycle.
- Simultaneous dispatch and commit: count += accept − commits.

Optional Feature:
- Macro ROB_BYPASS_EN.
- When defined: adds operand lookup ports rd_id[2] (ADDR_W each) in, rd_ready[2] out, rd_data[2] (32 each) out.
  - rd_ready=1 with stored data when entry[rd_id] is done.
  - Same-cycle write-back hits are forwarded combinationally, lowest channel first.
- When undefined: no such ports; II stage waits for regfile commit.

Decomposition:
- Header rob.v holds ROB_DEPTH_DEFAULT, the entry field widths and EXC_TYPE_IF/EXC_TYPE_NULL; exception.v is reused.
- One sub-module, rob_commit_select: purely combinational slot-enable, exception-detect and WAW-mask logic for COMMIT_WIDTH slots.

Test Plan:
- Reset, then dispatch 16 with no write-back → count=16, disp_ready=0, disp_id sequence 0..15; a 17th disp_valid is not accepted.
- Dispatch ids 0,1 writing r3 then r3; write back both; next cycle → commit_en=2'b11, commit_reg_write_en=2'b10, commit_reg_data[1] = id1 data, count −2.
- Write back id1 before id0 → no commit until id0 is done; then both retire in the same cycle, in order.
- Dispatch with pc=0x…02 (id0), then write back → exc_valid=1, exc_type=EXC_TYPE_IF, exc_pc=…02, commit_en=0; next cycle empty=1, head=tail=0.
- Fill to 15, wrap tail past DEPTH−1 while committing → ids wrap 15→0, no lost or duplicated entry; flush mid-stream → count=0 next cycle.
- Channels 0 and 1 both write id5 in the same cycle with data 0xA and 0xB → stored data 0xA.
